// File: rtl/sampler_reuse_resolver.sv
// sampler_reuse_resolver
//   Sits behind the sampler's valid/tag-match priority encoder. For each
//   accepted access that hit a sampler entry, it reads the entry's stored
//   timestamp and PC, computes the reuse interval (now - stored timestamp,
//   modulo 2^TS_W, clamped to RI_W bits) and offers it downstream with a
//   valid/ready handshake. It also pulses an invalidate for the matched
//   entry so the entry can be re-sampled.
//
//   Optional feature macro: SAMPLER_MISS_CNT_EN
//     When defined, adds stat_clr_i / miss_cnt_o, a saturating 32-bit count
//     of accepted accesses that matched no entry.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   req_valid_i  sampled access presented
//   req_ready_o  resolver can accept an access (IDLE only)
//   match_vld_i  encoder found a matching entry
//   match_idx_i  lowest matching entry index
//   rd_en_o      entry table read strobe
//   rd_idx_o     entry table read index
//   rd_ts_i      stored timestamp, valid one cycle after rd_en_o
//   rd_pc_i      stored PC, valid one cycle after rd_en_o
//   inv_en_o     one-cycle invalidate pulse
//   inv_idx_o    entry to invalidate
//   now_ts_o     current access timestamp
//   ri_valid_o   reuse interval result valid
//   ri_ready_i   downstream accepts result
//   ri_pc_o      PC of the reused entry
//   ri_value_o   reuse interval (clamped)
//   ri_sat_o     interval was clamped
//   stat_clr_i   (SAMPLER_MISS_CNT_EN) clear the miss count
//   miss_cnt_o   (SAMPLER_MISS_CNT_EN) saturating miss count

module sampler_reuse_resolver #(
    parameter int N_ENTRIES = 512,
    parameter int IDX_W     = $clog2(N_ENTRIES),
    parameter int TS_W      = 32,
    parameter int RI_W      = 24,
    parameter int PC_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             match_vld_i,
    input  logic [IDX_W-1:0] match_idx_i,
    output logic             rd_en_o,
    output logic [IDX_W-1:0] rd_idx_o,
    input  logic [TS_W-1:0]  rd_ts_i,
    input  logic [PC_W-1:0]  rd_pc_i,
    output logic             inv_en_o,
    output logic [IDX_W-1:0] inv_idx_o,
    output logic [TS_W-1:0]  now_ts_o,
    output logic             ri_valid_o,
    input  logic             ri_ready_i,
    output logic [PC_W-1:0]  ri_pc_o,
    output logic [RI_W-1:0]  ri_value_o,
    output logic             ri_sat_o
`ifdef SAMPLER_MISS_CNT_EN
    ,
    input  logic             stat_clr_i,
    output logic [31:0]      miss_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_CALC,
        ST_OUT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [TS_W-1:0]  now_ts;
    logic [TS_W-1:0]  cur_ts;
    logic [IDX_W-1:0] idx;
    logic [TS_W-1:0]  ts_q;
    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  ri_pc;
    logic [RI_W-1:0]  ri_value;
    logic             ri_sat;
    logic             accept;
    logic [TS_W-1:0]  diff;
    logic             diff_sat;

    // Internal accept ignores rst on purpose: flops are held in reset anyway,
    // and keeping rst out of the flop data paths avoids mixing it with sync logic.
    assign accept = req_valid_i && (state == ST_IDLE);

    // Unsigned modulo subtraction handles timestamp wrap-around for free.
    assign diff     = cur_ts - ts_q;
    assign diff_sat = |diff[TS_W-1:RI_W];

    // Next-state logic for the IDLE -> RD -> CALC -> OUT -> IDLE walk.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (req_valid_i && match_vld_i) state_next = ST_RD;
            ST_RD:   state_next = ST_CALC;
            ST_CALC: state_next = ST_OUT;
            ST_OUT:  if (ri_ready_i) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State, timestamp counter, captured table data and the result registers.
    // Table data is captured at the end of RD, the result at the end of CALC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            now_ts   <= '0;
            cur_ts   <= '0;
            idx      <= '0;
            ts_q     <= '0;
            pc_q     <= '0;
            ri_pc    <= '0;
            ri_value <= '0;
            ri_sat   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                now_ts <= now_ts + 1'b1;
                cur_ts <= now_ts;
                if (match_vld_i) begin
                    idx <= match_idx_i;
                end
            end
            if (state == ST_RD) begin
                ts_q <= rd_ts_i;
                pc_q <= rd_pc_i;
            end
            if (state == ST_CALC) begin
                ri_pc    <= pc_q;
                ri_sat   <= diff_sat;
                ri_value <= diff_sat ? {RI_W{1'b1}} : diff[RI_W-1:0];
            end
        end
    end

    // Combinational outputs are gated by rst so they read 0 while in reset,
    // even though the state register already sits in IDLE.
    assign req_ready_o = rst && (state == ST_IDLE);
    assign rd_en_o     = rst && accept && match_vld_i;
    assign rd_idx_o    = rd_en_o ? match_idx_i : '0;
    assign inv_en_o    = (state == ST_CALC);
    assign inv_idx_o   = idx;
    assign now_ts_o    = now_ts;
    assign ri_valid_o  = (state == ST_OUT);
    assign ri_pc_o     = ri_pc;
    assign ri_value_o  = ri_value;
    assign ri_sat_o    = ri_sat;

`ifdef SAMPLER_MISS_CNT_EN
    logic [31:0] miss_cnt;

    // Saturating miss counter; a clear takes priority over a same-cycle miss.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            miss_cnt <= '0;
        end else if (stat_clr_i) begin
            miss_cnt <= '0;
        end else if (accept && !match_vld_i && (miss_cnt != 32'hFFFF_FFFF)) begin
            miss_cnt <= miss_cnt + 32'd1;
        end
    end

    assign miss_cnt_o = miss_cnt;
`endif

endmodule

// File: tb/tb_sampler_reuse_resolver.sv
// Testbench for sampler_reuse_resolver: directed and randomized accesses
// against a reference model of timestamps, reuse intervals and miss counts.
// A small entry-table model answers rd_en_o one cycle later and drives
// random data at all other times.
module tb_sampler_reuse_resolver;

    localparam int IDX_W = 9;
    localparam int TS_W  = 32;
    localparam int RI_W  = 24;
    localparam int PC_W  = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid_i;
    logic             req_ready_o;
    logic             match_vld_i;
    logic [IDX_W-1:0] match_idx_i;
    logic             rd_en_o;
    logic [IDX_W-1:0] rd_idx_o;
    logic [TS_W-1:0]  rd_ts_i;
    logic [PC_W-1:0]  rd_pc_i;
    logic             inv_en_o;
    logic [IDX_W-1:0] inv_idx_o;
    logic [TS_W-1:0]  now_ts_o;
    logic             ri_valid_o;
    logic             ri_ready_i;
    logic [PC_W-1:0]  ri_pc_o;
    logic [RI_W-1:0]  ri_value_o;
    logic             ri_sat_o;
`ifdef SAMPLER_MISS_CNT_EN
    logic             stat_clr_i;
    logic [31:0]      miss_cnt_o;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] tbl_ts [512];
    logic [31:0] tbl_pc [512];
    logic [31:0] model_now;
    logic [31:0] model_miss;

    always #5 clk = ~clk;

    sampler_reuse_resolver dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .match_vld_i (match_vld_i),
        .match_idx_i (match_idx_i),
        .rd_en_o     (rd_en_o),
        .rd_idx_o    (rd_idx_o),
        .rd_ts_i     (rd_ts_i),
        .rd_pc_i     (rd_pc_i),
        .inv_en_o    (inv_en_o),
        .inv_idx_o   (inv_idx_o),
        .now_ts_o    (now_ts_o),
        .ri_valid_o  (ri_valid_o),
        .ri_ready_i  (ri_ready_i),
        .ri_pc_o     (ri_pc_o),
        .ri_value_o  (ri_value_o),
        .ri_sat_o    (ri_sat_o)
`ifdef SAMPLER_MISS_CNT_EN
        ,
        .stat_clr_i  (stat_clr_i),
        .miss_cnt_o  (miss_cnt_o)
`endif
    );

    // Entry table: data is valid the cycle after a read strobe, garbage otherwise.
    always @(posedge clk) begin
        if (rd_en_o) begin
            rd_ts_i <= tbl_ts[rd_idx_o];
            rd_pc_i <= tbl_pc[rd_idx_o];
        end else begin
            rd_ts_i <= $urandom;
            rd_pc_i <= $urandom;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkMissCount();
`ifdef SAMPLER_MISS_CNT_EN
        checkOutput("miss_cnt", miss_cnt_o, model_miss);
`endif
    endtask

    // One access from IDLE through to the end of its handshake, checked
    // against the reference model. hold = cycles of downstream backpressure.
    task automatic applyStimulus(input bit mvld, input logic [IDX_W-1:0] idx, input int hold);
        logic [31:0] cur;
        logic [31:0] d;
        logic [23:0] exp_val;
        bit          exp_sat;
        req_valid_i = 1'b1;
        match_vld_i = mvld;
        match_idx_i = idx;
        ri_ready_i  = 1'b0;
        #1;
        checkOutput("accept_ready", req_ready_o, 1);
        checkOutput("accept_rd_en", rd_en_o, mvld);
        if (mvld) checkOutput("rd_idx", rd_idx_o, idx);
        checkOutput("accept_now_ts", now_ts_o, model_now);
        checkOutput("accept_inv_en", inv_en_o, 0);
        cur       = model_now;
        model_now = model_now + 1;
`ifdef SAMPLER_MISS_CNT_EN
        if (stat_clr_i) model_miss = 0;
        else if (!mvld && model_miss != 32'hFFFF_FFFF) model_miss = model_miss + 1;
`endif
        step();
`ifdef SAMPLER_MISS_CNT_EN
        stat_clr_i = 1'b0;
`endif
        req_valid_i = 1'b0;
        if (!mvld) begin
            #1;
            checkOutput("miss_now_ts", now_ts_o, model_now);
            checkOutput("miss_ready", req_ready_o, 1);
            checkOutput("miss_ri_valid", ri_valid_o, 0);
            checkOutput("miss_inv_en", inv_en_o, 0);
            checkMissCount();
            return;
        end
        // RD: stray requests must not be accepted while busy
        req_valid_i = 1'($urandom_range(0, 1));
        match_vld_i = 1'b1;
        match_idx_i = IDX_W'($urandom);
        #1;
        checkOutput("rd_ready", req_ready_o, 0);
        checkOutput("rd_rd_en", rd_en_o, 0);
        checkOutput("rd_inv_en", inv_en_o, 0);
        checkOutput("rd_ri_valid", ri_valid_o, 0);
        step();
        // CALC
        #1;
        checkOutput("calc_inv_en", inv_en_o, 1);
        checkOutput("calc_inv_idx", inv_idx_o, idx);
        checkOutput("calc_rd_en", rd_en_o, 0);
        checkOutput("calc_ri_valid", ri_valid_o, 0);
        checkOutput("calc_ready", req_ready_o, 0);
        step();
        // OUT
        d       = cur - tbl_ts[idx];
        exp_sat = (d > 32'h00FF_FFFF);
        exp_val = exp_sat ? 24'hFF_FFFF : d[23:0];
        for (int c = 0; c <= hold; c++) begin
            ri_ready_i = (c == hold);
            #1;
            checkOutput("out_ri_valid", ri_valid_o, 1);
            checkOutput("out_ri_value", ri_value_o, exp_val);
            checkOutput("out_ri_sat", ri_sat_o, exp_sat);
            checkOutput("out_ri_pc", ri_pc_o, tbl_pc[idx]);
            checkOutput("out_inv_en", inv_en_o, 0);
            checkOutput("out_ready", req_ready_o, 0);
            checkOutput("out_now_ts", now_ts_o, model_now);
            step();
        end
        req_valid_i = 1'b0;
        match_vld_i = 1'b0;
        ri_ready_i  = 1'b0;
        #1;
        checkOutput("post_ri_valid", ri_valid_o, 0);
        checkOutput("post_ready", req_ready_o, 1);
        checkOutput("post_now_ts", now_ts_o, model_now);
        checkMissCount();
    endtask

    // Start a hit, then reset 'stage' cycles after accept (1=RD, 2=CALC, 3=OUT).
    task automatic resetMidway(input int stage);
        req_valid_i = 1'b1;
        match_vld_i = 1'b1;
        match_idx_i = IDX_W'($urandom);
        ri_ready_i  = 1'b0;
        step();
        req_valid_i = 1'b0;
        match_vld_i = 1'b0;
        repeat (stage - 1) step();
        #1;
        if (stage == 3) checkOutput("pre_reset_ri_valid", ri_valid_o, 1);
        rst = 1'b0;
        #1;
        checkOutput("rst_ri_valid", ri_valid_o, 0);
        checkOutput("rst_inv_en", inv_en_o, 0);
        checkOutput("rst_ready", req_ready_o, 0);
        checkOutput("rst_now_ts", now_ts_o, 0);
        step();
        checkOutput("rst_hold_inv_en", inv_en_o, 0);
        rst = 1'b1;
        #1;
        model_now  = 0;
        model_miss = 0;
        checkOutput("rst_rel_ready", req_ready_o, 1);
        checkOutput("rst_rel_inv_en", inv_en_o, 0);
        checkOutput("rst_rel_ri_valid", ri_valid_o, 0);
        checkMissCount();
        step();
        checkOutput("rst_after_inv_en", inv_en_o, 0);
        checkOutput("rst_after_ri_valid", ri_valid_o, 0);
    endtask

    initial begin
        logic [IDX_W-1:0] ridx;
        logic [31:0]      rdist;
        for (int i = 0; i < 512; i++) begin
            tbl_ts[i] = $urandom;
            tbl_pc[i] = $urandom;
        end
        model_now  = 0;
        model_miss = 0;
        rst         = 1'b0;
        req_valid_i = 1'b1;
        match_vld_i = 1'b1;
        match_idx_i = 9'd5;
        ri_ready_i  = 1'b1;
`ifdef SAMPLER_MISS_CNT_EN
        stat_clr_i  = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ready", req_ready_o, 0);
        checkOutput("reset_rd_en", rd_en_o, 0);
        checkOutput("reset_rd_idx", rd_idx_o, 0);
        checkOutput("reset_inv_en", inv_en_o, 0);
        checkOutput("reset_inv_idx", inv_idx_o, 0);
        checkOutput("reset_now_ts", now_ts_o, 0);
        checkOutput("reset_ri_valid", ri_valid_o, 0);
        checkOutput("reset_ri_value", ri_value_o, 0);
        checkOutput("reset_ri_sat", ri_sat_o, 0);
        checkOutput("reset_ri_pc", ri_pc_o, 0);
        checkMissCount();
        req_valid_i = 1'b0;
        match_vld_i = 1'b0;
        ri_ready_i  = 1'b0;
        rst         = 1'b1;
        #1;
        checkOutput("release_ready", req_ready_o, 1);
        checkOutput("release_now_ts", now_ts_o, 0);
        step();

        $display("[TB] misses, then a wrapped timestamp hit");
        applyStimulus(1'b0, IDX_W'($urandom), 0);
        applyStimulus(1'b0, IDX_W'($urandom), 0);
        tbl_ts[3] = 32'hFFFF_FFFE;
        applyStimulus(1'b1, 9'd3, 0);
        applyStimulus(1'b0, IDX_W'($urandom), 0);

        $display("[TB] hit at now_ts=10 with backpressure");
        while (model_now < 10) applyStimulus(1'b0, IDX_W'($urandom), 0);
        tbl_ts[37] = 32'd4;
        tbl_pc[37] = 32'h400;
        applyStimulus(1'b1, 9'd37, 5);

        $display("[TB] interval boundaries");
        tbl_ts[100] = model_now;
        applyStimulus(1'b1, 9'd100, 0);
        tbl_ts[200] = model_now - 32'h00FF_FFFF;
        applyStimulus(1'b1, 9'd200, 1);
        tbl_ts[201] = model_now - 32'h0100_0000;
        applyStimulus(1'b1, 9'd201, 0);
        tbl_ts[202] = model_now - 32'h0200_0000;
        applyStimulus(1'b1, 9'd202, 0);

`ifdef SAMPLER_MISS_CNT_EN
        $display("[TB] miss count clear against a simultaneous miss");
        stat_clr_i = 1'b1;
        applyStimulus(1'b0, IDX_W'($urandom), 0);
        applyStimulus(1'b0, IDX_W'($urandom), 0);
`endif

        $display("[TB] reset in RD, CALC and OUT");
        resetMidway(1);
        resetMidway(2);
        resetMidway(3);
        tbl_ts[511] = 32'hFFFF_FFF0;
        tbl_pc[511] = 32'hCAFE_0000;
        applyStimulus(1'b1, 9'd511, 2);

        $display("[TB] randomized accesses");
        for (int n = 0; n < 60; n++) begin
            ridx = IDX_W'($urandom);
            case ($urandom_range(0, 3))
                0:       rdist = $urandom_range(0, 1000);
                1:       rdist = 32'h00FF_FFFF + $urandom_range(0, 2) - 1;
                2:       rdist = $urandom;
                default: rdist = $urandom_range(0, 32'h00FF_FFFF);
            endcase
            tbl_ts[ridx] = model_now - rdist;
            tbl_pc[ridx] = $urandom;
            applyStimulus(1'($urandom_range(0, 2) != 0), ridx, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
